// File: rtl/cheri_rvfi_trace_fifo.sv
// -----------------------------------------------------------------------------
// cheri_rvfi_trace_fifo
//
// Retirement-trace capture buffer for the CHERIoT Ibex tracing top. It samples
// the RVFI retirement stream and keeps only the records selected by a runtime
// filter mode. Each accepted record is packed into one word and queued in a
// FIFO. The FIFO drains over a valid/ready stream. Records that arrive while
// the FIFO is full are counted in a saturating drop counter. The next record
// that is queued after a drop carries a "lost" marker.
//
// Optional feature (macro CHERI_TRACE_TIMESTAMP_EN):
//   When defined, a free-running 32-bit cycle counter is placed in front of
//   each record as ts[31:0], and RecW = OrderWidth+138. When undefined there is
//   no counter and no ts field, and RecW = OrderWidth+106.
//
// Record layout, MSB to LSB:
//   {[ts], lost, trap, intr, mem_is_cap, rd_wtag, rd_addr[4:0],
//    order[OrderWidth-1:0], pc, insn, rd_wdata}
//
// Ports:
//   clk_i, rst_i         clock; asynchronous active-high reset
//   trace_en_i           capture enable (the FIFO still drains when low)
//   filter_mode_i        0 all, 1 trap/intr, 2 capability-writing, 3 off
//   rvfi_*_i             RVFI retirement fields sampled on rvfi_valid_i
//   out_valid_o/ready_i  output stream handshake
//   out_rec_o            registered head record
//   level_o              FIFO occupancy
//   drop_cnt_o/clr_i     saturating count of dropped records, and its clear
// -----------------------------------------------------------------------------
module cheri_rvfi_trace_fifo #(
    parameter int Depth      = 16,
    parameter int OrderWidth = 16,
    parameter int CntWidth   = 16,
`ifdef CHERI_TRACE_TIMESTAMP_EN
    localparam int RecW      = OrderWidth + 138,
`else
    localparam int RecW      = OrderWidth + 106,
`endif
    localparam int LvlW      = $clog2(Depth) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  trace_en_i,
    input  logic [1:0]            filter_mode_i,
    input  logic                  rvfi_valid_i,
    input  logic [63:0]           rvfi_order_i,
    input  logic [31:0]           rvfi_insn_i,
    input  logic                  rvfi_trap_i,
    input  logic                  rvfi_intr_i,
    input  logic [31:0]           rvfi_pc_rdata_i,
    input  logic [4:0]            rvfi_rd_addr_i,
    input  logic [31:0]           rvfi_rd_wdata_i,
    input  logic                  rvfi_rd_wtag_i,
    input  logic                  rvfi_mem_is_cap_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [RecW-1:0]       out_rec_o,
    output logic [LvlW-1:0]       level_o,
    output logic [CntWidth-1:0]   drop_cnt_o,
    input  logic                  drop_clr_i
);

    localparam int AW = $clog2(Depth);

    // Pointers carry one extra wrap bit, so full and empty can be told apart.
    logic [AW:0]           wptr_q, wptr_d;
    logic [AW:0]           rptr_q, rptr_d;
    logic                  valid_q, valid_d;
    logic [AW:0]           level_q, level_d;
    logic                  lost_q, lost_d;
    logic [CntWidth-1:0]   drop_q, drop_d;
    logic [RecW-1:0]       rec_q, rec_d;
    logic [RecW-1:0]       mem_q [Depth];

    logic                  match;
    logic                  cand;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic [RecW-1:0]       new_rec;

    // Only the low OrderWidth bits of the order field are stored.
    logic                  unused_order;
    assign unused_order = ^rvfi_order_i;

`ifdef CHERI_TRACE_TIMESTAMP_EN
    logic [31:0]           ts_q, ts_d;
    assign ts_d    = ts_q + 32'd1;
    assign new_rec = {ts_q, lost_q, rvfi_trap_i, rvfi_intr_i, rvfi_mem_is_cap_i,
                      rvfi_rd_wtag_i, rvfi_rd_addr_i, rvfi_order_i[OrderWidth-1:0],
                      rvfi_pc_rdata_i, rvfi_insn_i, rvfi_rd_wdata_i};
`else
    assign new_rec = {lost_q, rvfi_trap_i, rvfi_intr_i, rvfi_mem_is_cap_i,
                      rvfi_rd_wtag_i, rvfi_rd_addr_i, rvfi_order_i[OrderWidth-1:0],
                      rvfi_pc_rdata_i, rvfi_insn_i, rvfi_rd_wdata_i};
`endif

    // NOTE: every variable in an always_comb gets a default before any
    // branch, so no path can leave it unassigned and infer a latch.
    always_comb begin
        match = 1'b0;
        unique case (filter_mode_i)
            2'd0:    match = 1'b1;
            2'd1:    match = rvfi_trap_i | rvfi_intr_i;
            2'd2:    match = rvfi_rd_wtag_i | rvfi_mem_is_cap_i;
            default: match = 1'b0;
        endcase
    end

    always_comb begin
        cand = rvfi_valid_i & trace_en_i & match;
        full = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        pop  = valid_q & out_ready_i;
        // A full FIFO still accepts a record if the head leaves in the same cycle.
        push = cand & (~full | pop);
        drop = cand & full & ~pop;

        wptr_d  = wptr_q + {{AW{1'b0}}, push};
        rptr_d  = rptr_q + {{AW{1'b0}}, pop};
        level_d = wptr_d - rptr_d;
        valid_d = (wptr_d != rptr_d);

        // The next head comes from storage. The exception is when the record
        // being written now becomes the head, because it is not in mem_q yet.
        if (push && (wptr_q == rptr_d)) begin
            rec_d = new_rec;
        end else begin
            rec_d = mem_q[rptr_d[AW-1:0]];
        end

        // Only a successful push consumes the lost marker. A push and a drop
        // cannot happen together, so the marker is never cleared by mistake.
        lost_d = lost_q;
        if (push) begin
            lost_d = 1'b0;
        end else if (drop) begin
            lost_d = 1'b1;
        end

        drop_d = drop_q;
        if (drop_clr_i) begin
            drop_d = drop ? {{(CntWidth-1){1'b0}}, 1'b1} : '0;
        end else if (drop && (drop_q != {CntWidth{1'b1}})) begin
            drop_d = drop_q + {{(CntWidth-1){1'b0}}, 1'b1};
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples its pre-edge inputs whatever the order of the blocks.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            valid_q <= 1'b0;
            level_q <= '0;
            lost_q  <= 1'b0;
            drop_q  <= '0;
            rec_q   <= '0;
`ifdef CHERI_TRACE_TIMESTAMP_EN
            ts_q    <= '0;
`endif
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            valid_q <= valid_d;
            level_q <= level_d;
            lost_q  <= lost_d;
            drop_q  <= drop_d;
            rec_q   <= rec_d;
`ifdef CHERI_TRACE_TIMESTAMP_EN
            ts_q    <= ts_d;
`endif
        end
    end

    // NOTE: the storage array has no reset. Its contents are only visible
    // through rec_q, which is reset. The empty pointers also keep stale
    // entries from being read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= new_rec;
        end
    end

    assign out_valid_o = valid_q;
    assign out_rec_o   = rec_q;
    assign level_o     = level_q;
    assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_cheri_rvfi_trace_fifo.sv
module tb_cheri_rvfi_trace_fifo;

    localparam int Depth      = 16;
    localparam int OrderWidth = 16;
    localparam int CntWidth   = 16;
`ifdef CHERI_TRACE_TIMESTAMP_EN
    localparam int RecW       = OrderWidth + 138;
`else
    localparam int RecW       = OrderWidth + 106;
`endif
    localparam int LvlW       = $clog2(Depth) + 1;

    // Field positions inside a packed record.
    localparam int PcLo    = 64;
    localparam int WtagBit = OrderWidth + 101;
    localparam int LostBit = OrderWidth + 105;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                trace_en_i;
    logic [1:0]          filter_mode_i;
    logic                rvfi_valid_i;
    logic [63:0]         rvfi_order_i;
    logic [31:0]         rvfi_insn_i;
    logic                rvfi_trap_i;
    logic                rvfi_intr_i;
    logic [31:0]         rvfi_pc_rdata_i;
    logic [4:0]          rvfi_rd_addr_i;
    logic [31:0]         rvfi_rd_wdata_i;
    logic                rvfi_rd_wtag_i;
    logic                rvfi_mem_is_cap_i;
    logic                out_valid_o;
    logic                out_ready_i;
    logic [RecW-1:0]     out_rec_o;
    logic [LvlW-1:0]     level_o;
    logic [CntWidth-1:0] drop_cnt_o;
    logic                drop_clr_i;

    cheri_rvfi_trace_fifo #(
        .Depth(Depth), .OrderWidth(OrderWidth), .CntWidth(CntWidth)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .trace_en_i(trace_en_i),
        .filter_mode_i(filter_mode_i), .rvfi_valid_i(rvfi_valid_i),
        .rvfi_order_i(rvfi_order_i), .rvfi_insn_i(rvfi_insn_i),
        .rvfi_trap_i(rvfi_trap_i), .rvfi_intr_i(rvfi_intr_i),
        .rvfi_pc_rdata_i(rvfi_pc_rdata_i), .rvfi_rd_addr_i(rvfi_rd_addr_i),
        .rvfi_rd_wdata_i(rvfi_rd_wdata_i), .rvfi_rd_wtag_i(rvfi_rd_wtag_i),
        .rvfi_mem_is_cap_i(rvfi_mem_is_cap_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_rec_o(out_rec_o), .level_o(level_o),
        .drop_cnt_o(drop_cnt_o), .drop_clr_i(drop_clr_i)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [RecW-1:0]     mq[$];
    int unsigned         m_cnt;
    bit                  m_lost;
    logic [31:0]         m_ts;

    function automatic logic [RecW-1:0] build_rec(input bit lost, input logic [31:0] ts);
        logic [RecW-1:0] r;
        r = {lost, rvfi_trap_i, rvfi_intr_i, rvfi_mem_is_cap_i, rvfi_rd_wtag_i,
             rvfi_rd_addr_i, rvfi_order_i[OrderWidth-1:0], rvfi_pc_rdata_i,
             rvfi_insn_i, rvfi_rd_wdata_i};
`ifdef CHERI_TRACE_TIMESTAMP_EN
        r[RecW-1 -: 32] = ts;
`else
        if (ts == 32'hFFFF_FFFF) r = r;  // the timestamp is not used in this build
`endif
        return r;
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mq.delete();
            m_cnt  = 0;
            m_lost = 0;
            m_ts   = 0;
        end else begin
            bit sel, cand, pop, push, drop;
            logic [RecW-1:0] r;
            case (filter_mode_i)
                2'd0:    sel = 1;
                2'd1:    sel = rvfi_trap_i || rvfi_intr_i;
                2'd2:    sel = rvfi_rd_wtag_i || rvfi_mem_is_cap_i;
                default: sel = 0;
            endcase
            cand = rvfi_valid_i && trace_en_i && sel;
            pop  = (mq.size() > 0) && out_ready_i;
            push = cand && (mq.size() < Depth || pop);
            drop = cand && !push;
            r = build_rec(m_lost, m_ts);
            if (pop)  void'(mq.pop_front());
            if (push) begin mq.push_back(r); m_lost = 0; end
            if (drop) m_lost = 1;
            if (drop_clr_i) m_cnt = drop ? 1 : 0;
            else if (drop && m_cnt < (1 << CntWidth) - 1) m_cnt++;
            m_ts = m_ts + 1;
        end
    end

    // Compare the outputs against the model on every falling edge.
    always @(negedge clk_i) begin
        check("out_valid", out_valid_o, mq.size() > 0);
        check("level", level_o, mq.size());
        check("drop_cnt", drop_cnt_o, m_cnt);
        if (mq.size() > 0) check("out_rec", out_rec_o, mq[0]);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_rec(input bit v, input bit trap, input bit intr,
                           input bit wtag, input bit mc, input logic [31:0] pc);
        rvfi_valid_i      = v;
        rvfi_trap_i       = trap;
        rvfi_intr_i       = intr;
        rvfi_rd_wtag_i    = wtag;
        rvfi_mem_is_cap_i = mc;
        rvfi_pc_rdata_i   = pc;
        rvfi_order_i      = {$urandom, $urandom};
        rvfi_insn_i       = $urandom;
        rvfi_rd_addr_i    = 5'($urandom);
        rvfi_rd_wdata_i   = $urandom;
    endtask

    task automatic drain();
        out_ready_i = 1;
        set_rec(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4 * Depth && out_valid_o; i++) step();
        check("drain_done", out_valid_o, 1'b0);
        out_ready_i = 0;
    endtask

    initial begin
        logic [RecW-1:0] h;
        rst_i = 1; trace_en_i = 1; filter_mode_i = 0; out_ready_i = 0; drop_clr_i = 0;
        set_rec(0, 0, 0, 0, 0, 0);
        step(); step();
        check("rst_valid", out_valid_o, 1'b0);
        check("rst_level", level_o, 0);
        check("rst_drop", drop_cnt_o, 0);
        check("rst_rec", out_rec_o, 0);
        rst_i = 0;

        // Three back-to-back retirements with the sink always ready.
        out_ready_i = 1;
        set_rec(1, 0, 0, 0, 0, 32'h100); step();
        h = out_rec_o;
        check("b2b_valid", out_valid_o, 1'b1);
        check("b2b_pc0", h[PcLo +: 32], 32'h100);
        check("b2b_lost0", h[LostBit], 1'b0);
        set_rec(1, 0, 0, 0, 0, 32'h104); step();
        h = out_rec_o;
        check("b2b_pc1", h[PcLo +: 32], 32'h104);
        check("b2b_level", level_o, 1);
        set_rec(1, 0, 0, 0, 0, 32'h108); step();
        h = out_rec_o;
        check("b2b_pc2", h[PcLo +: 32], 32'h108);
        set_rec(0, 0, 0, 0, 0, 0); step();
        check("b2b_empty", out_valid_o, 1'b0);

        // Overflow: 20 retirements with no sink, so 4 are dropped.
        out_ready_i = 0;
        for (int i = 0; i < 20; i++) begin set_rec(1, 0, 0, 0, 0, 32'h200 + 4 * i); step(); end
        set_rec(0, 0, 0, 0, 0, 0); step();
        check("ovf_level", level_o, 16);
        check("ovf_drop", drop_cnt_o, 4);
        drain();
        set_rec(1, 0, 0, 0, 0, 32'h300); step();
        set_rec(1, 0, 0, 0, 0, 32'h304); step();
        set_rec(0, 0, 0, 0, 0, 0); step();
        h = out_rec_o;
        check("lost_first", h[LostBit], 1'b1);
        out_ready_i = 1; step(); out_ready_i = 0;
        h = out_rec_o;
        check("lost_second", h[LostBit], 1'b0);
        drain();

        // A full FIFO with a push and a pop in the same cycle.
        for (int i = 0; i < 16; i++) begin set_rec(1, 0, 0, 0, 0, 32'h400 + 4 * i); step(); end
        set_rec(1, 0, 0, 0, 0, 32'h500); out_ready_i = 1; step();
        out_ready_i = 0; set_rec(0, 0, 0, 0, 0, 0);
        check("fullpp_level", level_o, 16);
        check("fullpp_drop", drop_cnt_o, 4);
        drain();
        drop_clr_i = 1; step(); drop_clr_i = 0;
        check("clr", drop_cnt_o, 0);

        // Filter modes.
        filter_mode_i = 2;
        set_rec(1, 0, 0, 0, 0, 32'h600); step();
        set_rec(1, 0, 0, 1, 0, 32'h604); step();
        set_rec(1, 0, 0, 0, 1, 32'h608); step();
        set_rec(0, 0, 0, 0, 0, 0); step();
        h = out_rec_o;
        check("mode2_level", level_o, 2);
        check("mode2_head_wtag", h[WtagBit], 1'b1);
        drain();
        filter_mode_i = 1;
        for (int i = 0; i < 4; i++) begin set_rec(1, i == 1, 0, 0, 0, 32'h700 + 4 * i); step(); end
        set_rec(0, 0, 0, 0, 0, 0); step();
        check("mode1_level", level_o, 1);
        drain();
        filter_mode_i = 3;
        for (int i = 0; i < 4; i++) begin set_rec(1, 1, 1, 1, 1, 32'h800); step(); end
        set_rec(0, 0, 0, 0, 0, 0); step();
        check("mode3_level", level_o, 0);
        filter_mode_i = 0;

        // Drop counter saturation, then a clear in the same cycle as a drop.
        set_rec(1, 0, 0, 0, 0, 32'h900);
        for (int i = 0; i < 16 + 65540; i++) step();
        check("sat_drop", drop_cnt_o, 16'hFFFF);
        drop_clr_i = 1; step(); drop_clr_i = 0;
        check("clr_with_drop", drop_cnt_o, 1);
        drain();

        // Asynchronous reset with 5 entries queued.
        for (int i = 0; i < 5; i++) begin set_rec(1, 0, 0, 0, 0, 32'hA00 + 4 * i); step(); end
        set_rec(0, 0, 0, 0, 0, 0);
        check("pre_rst_level", level_o, 5);
        #1 rst_i = 1;
        #1;
        check("async_rst_valid", out_valid_o, 1'b0);
        check("async_rst_level", level_o, 0);
        check("async_rst_drop", drop_cnt_o, 0);
        step(); step();
        rst_i = 0;

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            filter_mode_i = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
            trace_en_i    = ($urandom_range(0, 9) != 0);
            out_ready_i   = ($urandom_range(0, 2) != 0) ^ (i[9] && i[8]);
            drop_clr_i    = ($urandom_range(0, 49) == 0);
            set_rec($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom);
            step();
        end
        set_rec(0, 0, 0, 0, 0, 0); drop_clr_i = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
